// File: rtl/sn76489_wr_sched.sv
// sn76489_wr_sched
//   Write scheduler and bus controller for the sn76489 PSG core. Byte-write
//   requests from NUM_REQ requesters are arbitrated round-robin into a small
//   command FIFO. Each queued byte is then driven onto the PSG write bus with
//   the ce_n/we_n strobe, and the PSG ready handshake is honoured. A write
//   that never completes is aborted after TIMEOUT cycles.
//
// Ports:
//   clock_i       system clock, rising edge
//   res_n_i       asynchronous active-low reset
//   req_valid_i   per-requester write request
//   req_data_i    requester k byte at bits [8k+7:8k]
//   req_ready_o   one-hot accept; a transfer happens when valid & ready
//   ce_n_o        PSG chip enable (active low)
//   we_n_o        PSG write enable (active low)
//   d_o           PSG data bus, d_o[0] is the MSB (PSG bit order)
//   ready_i       PSG ready (1 = idle/accepting)
//   busy_o        FSM not idle or FIFO non-empty (registered)
//   fifo_level_o  current FIFO occupancy
//   grant_id_o    requester id of the byte currently on the PSG bus
//   timeout_o     one-cycle pulse when a write is aborted
module sn76489_wr_sched #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic                        clock_i,
  input  logic                        res_n_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [8*NUM_REQ-1:0]        req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        ce_n_o,
  output logic                        we_n_o,
  output logic [0:7]                  d_o,
  input  logic                        ready_i,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [1:0]                  grant_id_o,
  output logic                        timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [9:0]       head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  int               arb_idx;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [7:0]       push_data;
  logic             pop;
  logic [LVL_W-1:0] level_d;
  logic             busy_d;
  logic             ce_n_d, we_n_d, timeout_d;
  logic [0:7]       d_d;
  logic [1:0]       gid_d;

  assign head = fifo_mem[rd_ptr];

  // Round-robin arbiter. Works only from registered occupancy, so a pop in
  // the same cycle never lets an extra request in. Held off during reset.
  always_comb begin
    req_ready_o = '0;
    grant_any   = 1'b0;
    grant_idx   = '0;
    push_data   = '0;
    arb_idx     = 0;
    if (res_n_i && (fifo_level_o < LVL_W'(FIFO_DEPTH))) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        arb_idx = int'(rr_ptr) + i;
        if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!grant_any && (k == arb_idx) && req_valid_i[k]) begin
            grant_any      = 1'b1;
            grant_idx      = 2'(k);
            push_data      = req_data_i[8*k +: 8];
            req_ready_o[k] = 1'b1;
          end
        end
      end
    end
  end

  // Bus sequencer next state. The timeout counter is checked before the
  // handshake, so an abort wins over a normal transition on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ce_n_d    = ce_n_o;
    we_n_d    = we_n_o;
    d_d       = d_o;
    gid_d     = grant_id_o;
    timeout_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((fifo_level_o != '0) && ready_i) begin
          pop     = 1'b1;
          d_d     = head[7:0];
          gid_d   = head[9:8];
          ce_n_d  = 1'b0;
          we_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE, ST_WAIT: begin
        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ce_n_d    = 1'b1;
          we_n_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((state_q == ST_STROBE) && !ready_i) begin
            ce_n_d  = 1'b1;
            we_n_d  = 1'b1;
            state_d = ST_WAIT;
          end else if ((state_q == ST_WAIT) && ready_i) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy and busy as they will be after this edge.
  always_comb begin
    level_d = fifo_level_o;
    if (grant_any && !pop)      level_d = fifo_level_o + 1'b1;
    else if (!grant_any && pop) level_d = fifo_level_o - 1'b1;
    busy_d = (state_d != ST_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ce_n_o       <= 1'b1;
      we_n_o       <= 1'b1;
      d_o          <= '0;
      grant_id_o   <= '0;
      timeout_o    <= 1'b0;
      busy_o       <= 1'b0;
      fifo_level_o <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rr_ptr       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ce_n_o       <= ce_n_d;
      we_n_o       <= we_n_d;
      d_o          <= d_d;
      grant_id_o   <= gid_d;
      timeout_o    <= timeout_d;
      busy_o       <= busy_d;
      fifo_level_o <= level_d;
      if (grant_any) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock_i) begin
    if (grant_any) fifo_mem[wr_ptr] <= {grant_idx, push_data};
  end

endmodule

// File: tb/tb_sn76489_wr_sched.sv
// tb_sn76489_wr_sched
//   Self-checking bench for sn76489_wr_sched. Accepted requests are pushed to
//   a scoreboard queue and compared against each new PSG strobe. A simple PSG
//   model drives ready_i on the falling clock edge.
module tb_sn76489_wr_sched;

  logic        clock_i;
  logic        res_n_i;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_ready_o;
  logic        ce_n_o;
  logic        we_n_o;
  logic [0:7]  d_o;
  logic        ready_i;
  logic        busy_o;
  logic [2:0]  fifo_level_o;
  logic [1:0]  grant_id_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail = 0;
  int psg_mode = 0;
  int strobe_count = 0;
  int to_count = 0;
  logic [9:0] sb_q[$];

  typedef struct {
    logic [1:0] valid;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] exp_ready;
  } rr_vec_t;

  rr_vec_t rr_tab [12];
  logic [7:0] fb [6];

  sn76489_wr_sched #(.NUM_REQ(2), .FIFO_DEPTH(4), .TIMEOUT(63)) dut (
    .clock_i      (clock_i),
    .res_n_i      (res_n_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .ce_n_o       (ce_n_o),
    .we_n_o       (we_n_o),
    .d_o          (d_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .grant_id_o   (grant_id_o),
    .timeout_o    (timeout_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1);
    req_valid_i = valid;
    req_data_i  = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int w;
    w = 0;
    while ((busy_o || !ce_n_o) && w < 400) begin
      tick();
      w++;
    end
    checkOutput({name, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic waitLevelBelowFull();
    int w;
    w = 0;
    while (fifo_level_o == 3'd4 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) checkOutput("level_drain_wait", 32'(fifo_level_o), 32'd3);
  endtask

  // PSG model: drops ready half a cycle after seeing a strobe, keeps it low
  // for two more cycles, then raises it again. Modes 1/2 hold it stuck.
  initial begin
    int low_cnt;
    low_cnt = 0;
    ready_i = 1'b1;
    forever begin
      @(negedge clock_i);
      case (psg_mode)
        0: begin
          if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) ready_i = 1'b1;
          end else if (!ce_n_o && ready_i) begin
            ready_i = 1'b0;
            low_cnt = 2;
          end else if (ce_n_o) begin
            ready_i = 1'b1;
          end
        end
        1:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  end

  // Accepted requests, sampled mid-cycle, become scoreboard entries.
  initial begin
    forever begin
      @(negedge clock_i);
      if (res_n_i) begin
        for (int k = 0; k < 2; k++) begin
          if (req_valid_i[k] && req_ready_o[k]) sb_q.push_back({2'(k), req_data_i[8*k +: 8]});
        end
      end
    end
  end

  // Each new strobe must carry the oldest accepted byte and must only start
  // on an edge where ready_i was high.
  initial begin
    logic prev_ce;
    logic rdy_edge;
    logic ok;
    logic [9:0] exp;
    prev_ce = 1'b1;
    forever begin
      @(posedge clock_i);
      rdy_edge = ready_i;
      #1;
      if (res_n_i && timeout_o) to_count++;
      if (res_n_i && prev_ce && !ce_n_o) begin
        strobe_count++;
        checkOutput("strobe_ready_high", 32'(rdy_edge), 32'd1);
        checkOutput("strobe_we_n", 32'(we_n_o), 32'd0);
        ok = (sb_q.size() != 0);
        checkOutput("strobe_expected", 32'(ok), 32'd1);
        if (ok) begin
          exp = sb_q.pop_front();
          checkOutput("strobe_id", 32'(grant_id_o), 32'(exp[9:8]));
          checkOutput("strobe_byte", 32'(d_o), 32'(exp[7:0]));
        end
      end
      prev_ce = ce_n_o;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, k, s0, t0;
    logic acc;

    rr_tab[0]  = '{2'b00, 8'h80, 8'hC0, 2'b00};
    rr_tab[1]  = '{2'b01, 8'h81, 8'hC1, 2'b01};
    rr_tab[2]  = '{2'b11, 8'h82, 8'hC2, 2'b10};
    rr_tab[3]  = '{2'b11, 8'h83, 8'hC3, 2'b01};
    rr_tab[4]  = '{2'b11, 8'h84, 8'hC4, 2'b10};
    rr_tab[5]  = '{2'b11, 8'h85, 8'hC5, 2'b01};
    rr_tab[6]  = '{2'b10, 8'h86, 8'hC6, 2'b10};
    rr_tab[7]  = '{2'b01, 8'h87, 8'hC7, 2'b01};
    rr_tab[8]  = '{2'b01, 8'h88, 8'hC8, 2'b01};
    rr_tab[9]  = '{2'b11, 8'h89, 8'hC9, 2'b10};
    rr_tab[10] = '{2'b10, 8'h8A, 8'hCA, 2'b10};
    rr_tab[11] = '{2'b11, 8'h8B, 8'hCB, 2'b01};
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
    fb[3] = 8'h44; fb[4] = 8'h55; fb[5] = 8'h66;

    res_n_i = 1'b0;
    applyStimulus(2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clock_i);
    #1;
    applyStimulus(2'b11, 8'hAA, 8'hBB);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_ce_n", 32'(ce_n_o), 32'd1);
    checkOutput("rst_we_n", 32'(we_n_o), 32'd1);
    checkOutput("rst_d", 32'(d_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_level", 32'(fifo_level_o), 32'd0);
    checkOutput("rst_grant", 32'(grant_id_o), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
    applyStimulus(2'b00, 8'h00, 8'h00);
    @(negedge clock_i);
    res_n_i = 1'b1;
    tick();

    // Single write: strobe two cycles after the accept cycle.
    $display("[TB] single write");
    applyStimulus(2'b01, 8'h9F, 8'h00);
    #1;
    checkOutput("single_accept", 32'(req_ready_o), 32'd1);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00);
    checkOutput("single_pop_cycle_ce_n", 32'(ce_n_o), 32'd1);
    checkOutput("single_level", 32'(fifo_level_o), 32'd1);
    tick();
    checkOutput("single_ce_n", 32'(ce_n_o), 32'd0);
    checkOutput("single_we_n", 32'(we_n_o), 32'd0);
    checkOutput("single_d", 32'(d_o), 32'h9F);
    checkOutput("single_grant", 32'(grant_id_o), 32'd0);
    checkOutput("single_busy", 32'(busy_o), 32'd1);
    tick();
    checkOutput("single_release_ce_n", 32'(ce_n_o), 32'd1);
    checkOutput("single_release_we_n", 32'(we_n_o), 32'd1);
    waitIdle("single");
    checkOutput("single_d_hold", 32'(d_o), 32'h9F);

    // Round-robin table; RR pointer starts at 1 after the single write.
    $display("[TB] round-robin table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b00, 8'h00, 8'h00);
      waitLevelBelowFull();
      applyStimulus(rr_tab[i].valid, rr_tab[i].data0, rr_tab[i].data1);
      #1;
      checkOutput($sformatf("rr_ready_%0d", i), 32'(req_ready_o), 32'(rr_tab[i].exp_ready));
      tick();
    end
    applyStimulus(2'b00, 8'h00, 8'h00);
    waitIdle("rr");

    // FIFO full with PSG stalled, then drain in order.
    $display("[TB] fifo full");
    psg_mode = 1;
    tick();
    tick();
    n = 0;
    applyStimulus(2'b01, fb[0], 8'h00);
    repeat (10) begin
      @(negedge clock_i);
      acc = req_ready_o[0];
      tick();
      if (acc) n++;
      if (n < 6) applyStimulus(2'b01, fb[n], 8'h00);
      else applyStimulus(2'b00, 8'h00, 8'h00);
    end
    checkOutput("full_accepted", 32'(n), 32'd4);
    checkOutput("full_level", 32'(fifo_level_o), 32'd4);
    checkOutput("full_ready", 32'(req_ready_o), 32'd0);
    checkOutput("full_no_strobe", 32'(ce_n_o), 32'd1);
    psg_mode = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      @(negedge clock_i);
      acc = req_ready_o[0];
      tick();
      if (acc) n++;
      if (n < 6) applyStimulus(2'b01, fb[n], 8'h00);
      else applyStimulus(2'b00, 8'h00, 8'h00);
    end
    applyStimulus(2'b00, 8'h00, 8'h00);
    checkOutput("full_drain_accepted", 32'(n), 32'd6);
    waitIdle("full");

    // Back-to-back: three queued bytes, each a separate strobe.
    $display("[TB] back-to-back");
    psg_mode = 1;
    tick();
    tick();
    applyStimulus(2'b10, 8'h00, 8'hA1);
    tick();
    applyStimulus(2'b10, 8'h00, 8'hA2);
    tick();
    applyStimulus(2'b10, 8'h00, 8'hA3);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00);
    checkOutput("b2b_level", 32'(fifo_level_o), 32'd3);
    s0 = strobe_count;
    psg_mode = 0;
    waitIdle("b2b");
    checkOutput("b2b_strobes", 32'(strobe_count - s0), 32'd3);

    // Timeout: PSG never drops ready, write aborted after 63 cycles.
    $display("[TB] timeout");
    psg_mode = 2;
    t0 = to_count;
    tick();
    applyStimulus(2'b10, 8'h00, 8'hB1);
    tick();
    applyStimulus(2'b10, 8'h00, 8'hB2);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00);
    k = 0;
    while (ce_n_o && k < 10) begin
      tick();
      k++;
    end
    checkOutput("to_strobe_seen", 32'(ce_n_o), 32'd0);
    k = 0;
    while (!timeout_o && k < 200) begin
      tick();
      k++;
    end
    checkOutput("to_cycles", 32'(k), 32'd63);
    checkOutput("to_ce_n", 32'(ce_n_o), 32'd1);
    checkOutput("to_we_n", 32'(we_n_o), 32'd1);
    tick();
    checkOutput("to_pulse_width", 32'(timeout_o), 32'd0);
    checkOutput("to_next_issued", 32'(ce_n_o), 32'd0);
    psg_mode = 0;
    waitIdle("to");
    checkOutput("to_pulse_count", 32'(to_count - t0), 32'd1);

    // Reset during a strobe releases the bus without a clock edge.
    $display("[TB] reset mid-write");
    psg_mode = 2;
    tick();
    applyStimulus(2'b01, 8'hC1, 8'h00);
    tick();
    applyStimulus(2'b01, 8'hC2, 8'h00);
    tick();
    applyStimulus(2'b01, 8'hC3, 8'h00);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00);
    checkOutput("mid_level_before", 32'(fifo_level_o), 32'd2);
    checkOutput("mid_ce_n_before", 32'(ce_n_o), 32'd0);
    #2;
    res_n_i = 1'b0;
    #1;
    checkOutput("mid_ce_n", 32'(ce_n_o), 32'd1);
    checkOutput("mid_we_n", 32'(we_n_o), 32'd1);
    checkOutput("mid_level", 32'(fifo_level_o), 32'd0);
    checkOutput("mid_busy", 32'(busy_o), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    res_n_i = 1'b1;
    psg_mode = 0;
    tick();
    applyStimulus(2'b10, 8'h00, 8'hE4);
    #1;
    checkOutput("post_rst_ready", 32'(req_ready_o), 32'd2);
    tick();
    applyStimulus(2'b00, 8'h00, 8'h00);
    waitIdle("post_rst");
    checkOutput("post_rst_d", 32'(d_o), 32'hE4);
    checkOutput("post_rst_grant", 32'(grant_id_o), 32'd1);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
